// File: rtl/serial_add_pkg.sv
// Shared definitions for the slice-serial skip adder: FSM states and slice width.
package serial_add_pkg;

  localparam int SLICE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/skip_slice_4b.sv
// Combinational 4-bit ripple adder with a propagate-all carry bypass.
// When every bit propagates, the carry-out is taken straight from the carry-in
// and the skip flag is raised so the controller can count bypassed slices.
module skip_slice_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       skip_o
);

  logic [3:0] propagate;
  logic [3:0] generate_;
  logic [4:0] rippleCarry;

  assign propagate = a_i ^ b_i;
  assign generate_ = a_i & b_i;

  // Ripple the carry through the four bits and form the sum bits.
  always_comb begin
    rippleCarry    = '0;
    sum_o          = '0;
    rippleCarry[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]         = propagate[i] ^ rippleCarry[i];
      rippleCarry[i+1] = generate_[i] | (propagate[i] & rippleCarry[i]);
    end
  end

  // Bypass the ripple chain when all four bits propagate.
  always_comb begin
    skip_o = &propagate;
    cout_o = skip_o ? cin_i : rippleCarry[4];
  end

endmodule

// File: rtl/serial_skip_add_ctrl.sv
// Slice-serial adder controller: accepts A, B and carry-in, then adds one
// 4-bit slice per cycle (LSB first) through a single shared skip_slice_4b,
// and presents sum, carry-out and the number of bypassed slices in DONE.
module serial_skip_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = serial_add_pkg::SLICE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           cout,
  output logic [$clog2(WIDTH/SLICE):0]   skip_count
);

  import serial_add_pkg::*;

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CNTW   = $clog2(WIDTH / SLICE) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opA_q, opB_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [CNTW-1:0]   skipCnt_q;
  logic [IDXW-1:0]   sliceIdx_q;

  logic              accept;
  logic              lastSlice;
  logic [SLICE-1:0]  sliceA, sliceB, sliceSum;
  logic              sliceCout, sliceSkip;

  assign accept    = in_valid & in_ready;
  assign lastSlice = (sliceIdx_q == LAST_IDX);
  assign sliceA    = opA_q[sliceIdx_q*SLICE +: SLICE];
  assign sliceB    = opB_q[sliceIdx_q*SLICE +: SLICE];

  skip_slice_4b u_slice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout),
    .skip_o (sliceSkip)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept starts RUN, the last slice ends in DONE, and a consumed
  // result either chains straight into a new accept or drops back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (lastSlice) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  in_ready = 1'b0;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture on accept, then one slice of sum/carry/skip per RUN cycle.
  // Result registers only change in RUN or on accept, so they hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      skipCnt_q  <= '0;
      sliceIdx_q <= '0;
    end else if (accept) begin
      opA_q      <= a;
      opB_q      <= b;
      carry_q    <= cin;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      skipCnt_q  <= '0;
      sliceIdx_q <= '0;
    end else if (state_q == RUN) begin
      sum_q[sliceIdx_q*SLICE +: SLICE] <= sliceSum;
      carry_q    <= sliceCout;
      skipCnt_q  <= skipCnt_q + {{(CNTW-1){1'b0}}, sliceSkip};
      if (lastSlice) begin
        cout_q     <= sliceCout;
        sliceIdx_q <= '0;
      end else begin
        sliceIdx_q <= sliceIdx_q + 1'b1;
      end
    end
  end

  assign sum        = sum_q;
  assign cout       = cout_q;
  assign skip_count = skipCnt_q;

endmodule

// File: tb/tb_serial_skip_add_ctrl.sv
// Directed self-checking bench for serial_skip_add_ctrl at WIDTH=32, SLICE=4.
module tb_serial_skip_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic [3:0]  skip_count;

  int testsRun    = 0;
  int testsFailed = 0;

  serial_skip_add_ctrl #(.WIDTH(32), .SLICE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer operands for one cycle; returns one time unit after the accept edge
  // with garbage left on the operand inputs, which the DUT must ignore.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic vc);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    cin = ~vc;
  endtask

  // Wait (bounded) for out_valid after an accept and check latency and result.
  task automatic waitAndCheck(input string tag, input logic [31:0] expSum,
                              input logic expCout, input logic [3:0] expSkip);
    int lat = 0;
    checkOutput({tag, " in_ready in RUN"}, {63'd0, in_ready}, 64'd0);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'd8);
    checkOutput({tag, " sum"}, {32'd0, sum}, {32'd0, expSum});
    checkOutput({tag, " cout"}, {63'd0, cout}, {63'd0, expCout});
    checkOutput({tag, " skip_count"}, {60'd0, skip_count}, {60'd0, expSkip});
  endtask

  // Take the pending result and confirm the block returns to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after consume"}, {63'd0, out_valid}, 64'd0);
    checkOutput({tag, " in_ready after consume"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset sum", {32'd0, sum}, 64'd0);
    checkOutput("reset cout", {63'd0, cout}, 64'd0);
    checkOutput("reset skip_count", {60'd0, skip_count}, 64'd0);

    // All-ones plus one: slice 0 ripples, slices 1..7 bypass.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    waitAndCheck("ones+1", 32'h0000_0000, 1'b1, 4'd7);
    consume("ones+1");

    // No slice fully propagates.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
    waitAndCheck("nopp", 32'h2345_6789, 1'b0, 4'd0);

    // Hold the result for five cycles with out_ready low.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold sum", {32'd0, sum}, 64'h2345_6789);
      checkOutput("hold cout", {63'd0, cout}, 64'd0);
      checkOutput("hold skip_count", {60'd0, skip_count}, 64'd0);
      checkOutput("hold in_ready", {63'd0, in_ready}, 64'd0);
    end
    consume("nopp");

    // Every slice propagates, carry-in travels the whole word.
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    waitAndCheck("alt+cin", 32'h0000_0000, 1'b1, 4'd8);

    // Back-to-back: consume and accept a new operation in the same cycle.
    checkOutput("b2b in_ready low before", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("b2b in_ready with out_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(32'h0000_000F, 32'h0000_00F0, 1'b1);
    out_ready = 1'b0;
    checkOutput("b2b first result consumed", {63'd0, out_valid}, 64'd0);
    waitAndCheck("b2b second", 32'h0000_0100, 1'b0, 4'd2);
    consume("b2b second");

    // MSB-only carry out with no bypassed slice.
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
    waitAndCheck("msb", 32'h0000_0000, 1'b1, 4'd0);
    consume("msb");

    // Reset during the third RUN cycle aborts the operation.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort sum", {32'd0, sum}, 64'd0);
    checkOutput("abort skip_count", {60'd0, skip_count}, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("abort no result", 64'(seen), 64'd0);

    // The block still works after the abort.
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0);
    waitAndCheck("post-abort", 32'h0000_0003, 1'b0, 4'd0);
    consume("post-abort");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
